axi_lite_arbiter: RTL and testbench

AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

---
 rtl/axi_lite_arbiter_if.sv | 39 +++
 rtl/axi_lite_arbiter.sv | 166 ++++++++++++++++
 tb/tb_axi_lite_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_arbiter_if.sv
// AXI4-Lite channel bundle used between the arbiter, its two requesters and the shared slave.
interface axi_lite_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;

    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;

    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;

    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_arbiter.sv
// Two-master AXI4-Lite arbiter with a single outstanding transaction on the shared slave.
// Define ARB_ROUND_ROBIN_EN for round-robin resolution of simultaneous requests; default is fixed priority.
module axi_lite_arbiter #(
    parameter int unsigned DEF_OWNER = 0
) (
    input logic        clk,
    input logic        reset,
    axi_lite_if.slave  m0,
    axi_lite_if.slave  m1,
    axi_lite_if.master s
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam logic        DEF_BIT = 1'(DEF_OWNER);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR,
        WR_RESP
    } state_t;

    state_t state;
    logic   owner;
    logic   aw_done;
    logic   w_done;

    logic   req0;
    logic   req1;
    logic   grant;
    logic   grant_rd;

    logic   active;
    logic   in_rd_addr;
    logic   in_rd_data;
    logic   in_wr_addr;
    logic   in_wr_resp;

    logic   ar_hs;
    logic   r_hs;
    logic   aw_hs;
    logic   w_hs;
    logic   b_hs;

    logic              own_arvalid;
    logic              own_awvalid;
    logic              own_wvalid;
    logic              own_rready;
    logic              own_bready;
    logic [ADDR_W-1:0] own_araddr;
    logic [ADDR_W-1:0] own_awaddr;
    logic [DATA_W-1:0] own_wdata;
    logic [STRB_W-1:0] own_wstrb;

    assign req0 = m0.arvalid | m0.awvalid;
    assign req1 = m1.arvalid | m1.awvalid;

`ifdef ARB_ROUND_ROBIN_EN
    // Points at the master that wins the next tie; it always names the one not granted last.
    logic rr_ptr;
    assign grant = (req0 && req1) ? rr_ptr : req1;
`else
    assign grant = (req0 && req1) ? DEF_BIT : req1;
`endif

    // Read wins over write when the winner presents both.
    assign grant_rd = grant ? m1.arvalid : m0.arvalid;

    // Reset gates every phase so the buses go quiet while reset is held.
    assign active     = reset && (state != IDLE);
    assign in_rd_addr = reset && (state == RD_ADDR);
    assign in_rd_data = reset && (state == RD_DATA);
    assign in_wr_addr = reset && (state == WR_ADDR);
    assign in_wr_resp = reset && (state == WR_RESP);

    assign own_arvalid = owner ? m1.arvalid : m0.arvalid;
    assign own_awvalid = owner ? m1.awvalid : m0.awvalid;
    assign own_wvalid  = owner ? m1.wvalid  : m0.wvalid;
    assign own_rready  = owner ? m1.rready  : m0.rready;
    assign own_bready  = owner ? m1.bready  : m0.bready;
    assign own_araddr  = owner ? m1.araddr  : m0.araddr;
    assign own_awaddr  = owner ? m1.awaddr  : m0.awaddr;
    assign own_wdata   = owner ? m1.wdata   : m0.wdata;
    assign own_wstrb   = owner ? m1.wstrb   : m0.wstrb;

    // Downstream request side: owner channels pass through only in their phase.
    assign s.araddr  = active ? own_araddr : '0;
    assign s.awaddr  = active ? own_awaddr : '0;
    assign s.wdata   = active ? own_wdata  : '0;
    assign s.wstrb   = active ? own_wstrb  : '0;
    assign s.arvalid = in_rd_addr && own_arvalid;
    assign s.awvalid = in_wr_addr && own_awvalid && !aw_done;
    assign s.wvalid  = in_wr_addr && own_wvalid  && !w_done;
    assign s.rready  = in_rd_data && own_rready;
    assign s.bready  = in_wr_resp && own_bready;

    // Upstream return side toward m0.
    assign m0.arready = in_rd_addr && !owner && s.arready;
    assign m0.awready = in_wr_addr && !owner && !aw_done && s.awready;
    assign m0.wready  = in_wr_addr && !owner && !w_done  && s.wready;
    assign m0.rvalid  = in_rd_data && !owner && s.rvalid;
    assign m0.rdata   = (in_rd_data && !owner) ? s.rdata : '0;
    assign m0.rresp   = (in_rd_data && !owner) ? s.rresp : 2'b00;
    assign m0.bvalid  = in_wr_resp && !owner && s.bvalid;
    assign m0.bresp   = (in_wr_resp && !owner) ? s.bresp : 2'b00;

    // Upstream return side toward m1.
    assign m1.arready = in_rd_addr && owner && s.arready;
    assign m1.awready = in_wr_addr && owner && !aw_done && s.awready;
    assign m1.wready  = in_wr_addr && owner && !w_done  && s.wready;
    assign m1.rvalid  = in_rd_data && owner && s.rvalid;
    assign m1.rdata   = (in_rd_data && owner) ? s.rdata : '0;
    assign m1.rresp   = (in_rd_data && owner) ? s.rresp : 2'b00;
    assign m1.bvalid  = in_wr_resp && owner && s.bvalid;
    assign m1.bresp   = (in_wr_resp && owner) ? s.bresp : 2'b00;

    assign ar_hs = s.arvalid && s.arready;
    assign r_hs  = s.rvalid  && s.rready;
    assign aw_hs = s.awvalid && s.awready;
    assign w_hs  = s.wvalid  && s.wready;
    assign b_hs  = s.bvalid  && s.bready;

    // Transaction sequencer; owner and done flags only change at grant or on their own handshake.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            owner   <= DEF_BIT;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner   <= grant;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= grant_rd ? RD_ADDR : WR_ADDR;
`ifdef ARB_ROUND_ROBIN_EN
                        rr_ptr  <= !grant;
`endif
                    end
                end
                RD_ADDR: begin
                    if (ar_hs) state <= RD_DATA;
                end
                RD_DATA: begin
                    if (r_hs) state <= IDLE;
                end
                WR_ADDR: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                    if ((aw_done || aw_hs) && (w_done || w_hs)) state <= WR_RESP;
                end
                WR_RESP: begin
                    if (b_hs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter: grant latency, priority, split write handshakes, SLVERR, mid-flight reset.
module tb_axi_lite_arbiter;
    logic clk = 1'b0;
    logic reset;
    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;
    int unsigned w_cnt  = 0;
    int unsigned b_cnt  = 0;
    bit exp_own;

    axi_lite_if m0_if ();
    axi_lite_if m1_if ();
    axi_lite_if s_if ();

    axi_lite_arbiter #(.DEF_OWNER(0)) dut (
        .clk   (clk),
        .reset (reset),
        .m0    (m0_if),
        .m1    (m1_if),
        .s     (s_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Every valid/ready the arbiter drives, packed so a quiet bus compares against zero.
    function automatic logic [31:0] hs_bits();
        return 32'({s_if.arvalid, s_if.awvalid, s_if.wvalid, s_if.rready, s_if.bready,
                    m0_if.arready, m0_if.awready, m0_if.wready, m0_if.rvalid, m0_if.bvalid,
                    m1_if.arready, m1_if.awready, m1_if.wready, m1_if.rvalid, m1_if.bvalid});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_masters();
        m0_if.arvalid = 1'b0; m0_if.araddr = '0; m0_if.rready = 1'b0;
        m0_if.awvalid = 1'b0; m0_if.awaddr = '0; m0_if.wvalid = 1'b0;
        m0_if.wdata   = '0;   m0_if.wstrb  = '0; m0_if.bready = 1'b0;
        m1_if.arvalid = 1'b0; m1_if.araddr = '0; m1_if.rready = 1'b0;
        m1_if.awvalid = 1'b0; m1_if.awaddr = '0; m1_if.wvalid = 1'b0;
        m1_if.wdata   = '0;   m1_if.wstrb  = '0; m1_if.bready = 1'b0;
    endtask

    task automatic clear_slave();
        s_if.arready = 1'b0; s_if.rvalid = 1'b0; s_if.rdata = '0; s_if.rresp = 2'b00;
        s_if.awready = 1'b0; s_if.wready = 1'b0; s_if.bvalid = 1'b0; s_if.bresp = 2'b00;
    endtask

    initial begin
        // Reset: requests and a ready slave must not leak onto any bus.
        reset = 1'b0;
        clear_masters();
        clear_slave();
        tick();
        m0_if.arvalid = 1'b1; m0_if.araddr = 32'h1111_0000; m1_if.awvalid = 1'b1;
        s_if.arready = 1'b1;
        @(negedge clk);
        check("rst_quiet", hs_bits(), 32'h0);
        check("rst_araddr", s_if.araddr, 32'h0);
        tick();
        reset = 1'b1;
        clear_masters();
        clear_slave();
        @(negedge clk);
        check("post_rst_quiet", hs_bits(), 32'h0);

        // Lone m0 read, one-cycle slave.
        tick();
        m0_if.arvalid = 1'b1; m0_if.araddr = 32'ha000_0048; m0_if.rready = 1'b1;
        s_if.arready = 1'b1;
        @(negedge clk);
        check("rd_c0_quiet", hs_bits(), 32'h0);
        tick();
        @(negedge clk);
        check("rd_c1_arvalid", 32'(s_if.arvalid), 32'h1);
        check("rd_c1_araddr", s_if.araddr, 32'ha000_0048);
        check("rd_c1_m0_arready", 32'(m0_if.arready), 32'h1);
        check("rd_c1_m1_ready", 32'({m1_if.arready, m1_if.awready, m1_if.wready}), 32'h0);
        tick();
        m0_if.arvalid = 1'b0; m0_if.araddr = '0;
        s_if.rvalid = 1'b1; s_if.rdata = 32'h1234_5678;
        @(negedge clk);
        check("rd_c2_rvalid", 32'({m0_if.rvalid, m1_if.rvalid, s_if.rready, s_if.arvalid}), 32'hA);
        check("rd_c2_rdata", m0_if.rdata, 32'h1234_5678);
        tick();
        s_if.rvalid = 1'b0; m0_if.rready = 1'b0;
        @(negedge clk);
        check("rd_c3_quiet", hs_bits(), 32'h0);
        check("rd_c3_araddr", s_if.araddr, 32'h0);

        // Simultaneous m0 read and m1 write: m0 first, then one bubble, then m1.
        tick();
        m0_if.arvalid = 1'b1; m0_if.araddr = 32'h0000_1000; m0_if.rready = 1'b1;
        m1_if.awvalid = 1'b1; m1_if.awaddr = 32'h8000_0000;
        m1_if.wvalid  = 1'b1; m1_if.wdata  = 32'hdead_beef; m1_if.wstrb = 4'hf;
        m1_if.bready  = 1'b1;
        s_if.arready = 1'b1; s_if.awready = 1'b1; s_if.wready = 1'b1;
        @(negedge clk);
        check("pri_idle", hs_bits(), 32'h0);
        tick();
        @(negedge clk);
        check("pri_grant_m0", 32'({s_if.arvalid, s_if.awvalid, s_if.wvalid}), 32'h4);
        check("pri_araddr", s_if.araddr, 32'h0000_1000);
        check("pri_m1_held", 32'({m1_if.awready, m1_if.wready}), 32'h0);
        tick();
        m0_if.arvalid = 1'b0;
        s_if.rvalid = 1'b1; s_if.rdata = 32'hcafe_0001;
        @(negedge clk);
        check("pri_m0_rvalid", 32'({m0_if.rvalid, s_if.awvalid}), 32'h2);
        check("pri_m0_rdata", m0_if.rdata, 32'hcafe_0001);
        tick();
        s_if.rvalid = 1'b0; m0_if.rready = 1'b0;
        @(negedge clk);
        check("pri_bubble", hs_bits(), 32'h0);
        tick();
        @(negedge clk);
        check("pri_grant_m1", 32'({s_if.arvalid, s_if.awvalid, s_if.wvalid}), 32'h3);
        check("pri_awaddr", s_if.awaddr, 32'h8000_0000);
        check("pri_wdata", s_if.wdata, 32'hdead_beef);
        check("pri_wstrb", 32'(s_if.wstrb), 32'hf);
        check("pri_m1_ready", 32'({m1_if.awready, m1_if.wready, m0_if.arready}), 32'h6);
        tick();
        m1_if.awvalid = 1'b0; m1_if.wvalid = 1'b0;
        s_if.bvalid = 1'b1; s_if.bresp = 2'b00;
        @(negedge clk);
        check("pri_m1_bvalid", 32'({m1_if.bvalid, m0_if.bvalid, s_if.bready}), 32'h5);
        check("pri_m1_bresp", 32'(m1_if.bresp), 32'h0);
        tick();
        s_if.bvalid = 1'b0; m1_if.bready = 1'b0;
        @(negedge clk);
        check("pri_done_quiet", hs_bits(), 32'h0);

        // Both masters requesting at every grant, always-ready slave: 3 cycles per transaction.
        tick();
        m0_if.arvalid = 1'b1; m0_if.araddr = 32'h0000_7000; m0_if.rready = 1'b1;
        m1_if.awvalid = 1'b1; m1_if.awaddr = 32'h0000_7004;
        m1_if.wvalid  = 1'b1; m1_if.wdata  = 32'h0000_00aa; m1_if.wstrb = 4'h1;
        m1_if.bready  = 1'b1;
        s_if.arready = 1'b1; s_if.awready = 1'b1; s_if.wready = 1'b1;
        s_if.rvalid  = 1'b1; s_if.rdata   = 32'h0bad_f00d; s_if.bvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_own = bit'(k % 2);
`else
            exp_own = 1'b0;
`endif
            @(negedge clk);
            check("arb_idle", hs_bits(), 32'h0);
            tick();
            @(negedge clk);
            check("arb_grant", 32'({s_if.arvalid, s_if.awvalid}), 32'(exp_own ? 2'b01 : 2'b10));
            tick();
            @(negedge clk);
            check("arb_resp", 32'({m0_if.rvalid, m1_if.bvalid}), 32'(exp_own ? 2'b01 : 2'b10));
            tick();
            if (k == 3) begin
                clear_masters();
                clear_slave();
            end
        end
        @(negedge clk);
        check("arb_done_quiet", hs_bits(), 32'h0);

        // m0 write where the slave takes W two cycles before AW; W valid stays up from the master.
        tick();
        m0_if.awvalid = 1'b1; m0_if.awaddr = 32'h2000_0010;
        m0_if.wvalid  = 1'b1; m0_if.wdata  = 32'h55aa_55aa; m0_if.wstrb = 4'h3;
        m0_if.bready  = 1'b1;
        s_if.awready = 1'b0; s_if.wready = 1'b1;
        @(negedge clk);
        check("split_idle", hs_bits(), 32'h0);
        tick();
        @(negedge clk);
        check("split_c1_valid", 32'({s_if.awvalid, s_if.wvalid, m0_if.awready, m0_if.wready}), 32'hD);
        w_cnt += 32'(s_if.wvalid && s_if.wready);
        tick();
        @(negedge clk);
        check("split_c2_valid", 32'({s_if.awvalid, s_if.wvalid, m0_if.awready, m0_if.wready}), 32'h8);
        w_cnt += 32'(s_if.wvalid && s_if.wready);
        tick();
        s_if.awready = 1'b1;
        @(negedge clk);
        check("split_c3_valid", 32'({s_if.awvalid, s_if.wvalid, m0_if.awready, m0_if.wready}), 32'hA);
        check("split_awaddr", s_if.awaddr, 32'h2000_0010);
        check("split_wstrb", 32'(s_if.wstrb), 32'h3);
        w_cnt += 32'(s_if.wvalid && s_if.wready);
        tick();
        m0_if.awvalid = 1'b0; m0_if.wvalid = 1'b0;
        s_if.awready = 1'b0; s_if.bvalid = 1'b1; s_if.bresp = 2'b00;
        @(negedge clk);
        check("split_resp", 32'({m0_if.bvalid, s_if.awvalid, s_if.wvalid}), 32'h4);
        w_cnt += 32'(s_if.wvalid && s_if.wready);
        b_cnt += 32'(m0_if.bvalid && m0_if.bready);
        tick();
        s_if.bvalid = 1'b0; m0_if.bready = 1'b0;
        @(negedge clk);
        b_cnt += 32'(m0_if.bvalid && m0_if.bready);
        check("split_quiet", hs_bits(), 32'h0);
        check("split_w_count", w_cnt, 32'd1);
        check("split_b_count", b_cnt, 32'd1);

        // m1 CLINT write returning SLVERR while m0 waits, then m0 read also returning SLVERR.
        tick();
        m1_if.awvalid = 1'b1; m1_if.awaddr = 32'h0200_4000;
        m1_if.wvalid  = 1'b1; m1_if.wdata  = 32'h0000_0001; m1_if.wstrb = 4'hf;
        m1_if.bready  = 1'b1;
        s_if.awready = 1'b1; s_if.wready = 1'b1;
        @(negedge clk);
        check("err_idle", hs_bits(), 32'h0);
        tick();
        m0_if.arvalid = 1'b1; m0_if.araddr = 32'h0000_3000; m0_if.rready = 1'b1;
        s_if.arready = 1'b1;
        @(negedge clk);
        check("err_wr_grant", 32'({s_if.arvalid, s_if.awvalid, s_if.wvalid, m0_if.arready}), 32'h6);
        tick();
        m1_if.awvalid = 1'b0; m1_if.wvalid = 1'b0;
        s_if.bvalid = 1'b1; s_if.bresp = 2'b10;
        @(negedge clk);
        check("err_bvalid", 32'({m1_if.bvalid, m0_if.bvalid, m0_if.arready, s_if.arvalid}), 32'h8);
        check("err_bresp", 32'(m1_if.bresp), 32'h2);
        tick();
        s_if.bvalid = 1'b0; s_if.bresp = 2'b00; m1_if.bready = 1'b0;
        @(negedge clk);
        check("err_bubble", hs_bits(), 32'h0);
        tick();
        @(negedge clk);
        check("err_m0_grant", 32'({s_if.arvalid, m0_if.arready}), 32'h3);
        check("err_m0_araddr", s_if.araddr, 32'h0000_3000);
        tick();
        m0_if.arvalid = 1'b0;
        s_if.rvalid = 1'b1; s_if.rresp = 2'b10; s_if.rdata = 32'h0000_feed;
        @(negedge clk);
        check("err_m0_rvalid", 32'(m0_if.rvalid), 32'h1);
        check("err_rresp", 32'(m0_if.rresp), 32'h2);
        check("err_rdata", m0_if.rdata, 32'h0000_feed);
        tick();
        s_if.rvalid = 1'b0; s_if.rresp = 2'b00; m0_if.rready = 1'b0;
        @(negedge clk);
        check("err_done_quiet", hs_bits(), 32'h0);

        // Reset asserted while m1 waits in the read data phase.
        tick();
        m1_if.arvalid = 1'b1; m1_if.araddr = 32'h0000_4000; m1_if.rready = 1'b1;
        s_if.arready = 1'b1;
        @(negedge clk);
        check("mrst_idle", hs_bits(), 32'h0);
        tick();
        @(negedge clk);
        check("mrst_grant", 32'({s_if.arvalid, m1_if.arready}), 32'h3);
        check("mrst_araddr", s_if.araddr, 32'h0000_4000);
        tick();
        m1_if.arvalid = 1'b0;
        @(negedge clk);
        check("mrst_rd_data", 32'({s_if.rready, m1_if.rvalid}), 32'h2);
        reset = 1'b0;
        #1;
        check("mrst_held_quiet", hs_bits(), 32'h0);
        check("mrst_held_araddr", s_if.araddr, 32'h0);
        tick();
        reset = 1'b1;
        s_if.rvalid = 1'b1; s_if.rdata = 32'hdead_0001;
        m0_if.arvalid = 1'b1; m0_if.araddr = 32'h0000_5000; m0_if.rready = 1'b1;
        @(negedge clk);
        check("mrst_after_quiet", hs_bits(), 32'h0);
        tick();
        s_if.rvalid = 1'b0; m1_if.rready = 1'b0;
        @(negedge clk);
        check("mrst_fresh_grant", 32'({s_if.arvalid, m0_if.arready, m1_if.arready}), 32'h6);
        check("mrst_fresh_araddr", s_if.araddr, 32'h0000_5000);
        tick();
        m0_if.arvalid = 1'b0;
        s_if.rvalid = 1'b1; s_if.rdata = 32'h600d_0001;
        @(negedge clk);
        check("mrst_fresh_rvalid", 32'({m0_if.rvalid, m1_if.rvalid}), 32'h2);
        check("mrst_fresh_rdata", m0_if.rdata, 32'h600d_0001);
        tick();
        clear_masters();
        clear_slave();
        @(negedge clk);
        check("final_quiet", hs_bits(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
